// File: rtl/pwm_cfg_pkg.sv
// Shared parameter defaults, FSM state encoding and per-channel config record for pwm_cfg_controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pwm_cfg_pkg;

   localparam int NUM_CH_DEF    = 4;
   localparam int DUTY_MAX_DEF  = 100;
   localparam int RAMP_STEP_DEF = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_COMMIT  = 2'd2
   } pwm_state_t;

   typedef struct packed {
      logic [7:0] duty;
      logic       polarity;
      logic       edge_mode;
   } ch_cfg_t;

endpackage

// File: rtl/pwm_cfg_shadow.sv
// One channel: shadow, active and pending registers; duty steps toward shadow on commit (PWM_RAMP_EN).
// Latency: shadow/pending update on the write edge, active updates on the commit edge.
// Backpressure: none here; the controller never issues a write and a commit together.
module pwm_cfg_shadow
   import pwm_cfg_pkg::*;
#(
   parameter int RAMP_STEP = RAMP_STEP_DEF
) (
   input  logic    clk,
   input  logic    reset_n,
   input  logic    i_wr,
   input  ch_cfg_t i_wr_cfg,
   input  logic    i_commit,
   output ch_cfg_t o_active,
   output logic    o_pending,
   output logic    o_pending_nxt
);

`ifdef PWM_RAMP_EN
   localparam bit RAMP_EN = 1'b1;
`else
   localparam bit RAMP_EN = 1'b0;
`endif
   // Without ramping the step is unbounded, so one commit always lands on the shadow value.
   localparam int         STEP_LIM = (RAMP_EN && (RAMP_STEP < 255)) ? RAMP_STEP : 255;
   localparam logic [7:0] STEP     = 8'(STEP_LIM);

   ch_cfg_t    r_shadow;
   ch_cfg_t    r_active;
   logic       r_pend;
   logic [7:0] w_diff;
   logic [7:0] w_next_duty;

   always_comb begin
      w_diff      = 8'd0;
      w_next_duty = r_shadow.duty;
      if (r_shadow.duty > r_active.duty) begin
         w_diff = r_shadow.duty - r_active.duty;
         if (w_diff > STEP) w_next_duty = r_active.duty + STEP;
      end else begin
         w_diff = r_active.duty - r_shadow.duty;
         if (w_diff > STEP) w_next_duty = r_active.duty - STEP;
      end
   end

   assign o_pending_nxt = r_pend && (w_next_duty != r_shadow.duty);
   assign o_active      = r_active;
   assign o_pending     = r_pend;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shadow <= '0;
         r_active <= '0;
         r_pend   <= 1'b0;
      end else if (i_wr) begin
         r_shadow <= i_wr_cfg;
         r_pend   <= 1'b1;
      end else if (i_commit && r_pend) begin
         r_active <= '{duty: w_next_duty, polarity: r_shadow.polarity, edge_mode: r_shadow.edge_mode};
         r_pend   <= o_pending_nxt;
      end
   end

endmodule

// File: rtl/pwm_cfg_controller.sv
// Shadowed PWM channel config, committed to active outputs on period_end; ramped duty with PWM_RAMP_EN.
// Latency: period_end in cycle M -> commit_o in M+1 -> active outputs in M+2.
// Backpressure: cfg_ready low only during the single COMMIT cycle (and in reset).
module pwm_cfg_controller
   import pwm_cfg_pkg::*;
#(
   parameter int NUM_CH    = NUM_CH_DEF,
   parameter int DUTY_MAX  = DUTY_MAX_DEF,
   parameter int RAMP_STEP = RAMP_STEP_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [1:0]          cfg_channel,
   input  logic [7:0]          cfg_duty,
   input  logic                cfg_polarity,
   input  logic                cfg_edge_mode,
   input  logic                period_end,
   output logic [8*NUM_CH-1:0] duty_o,
   output logic [NUM_CH-1:0]   polarity_o,
   output logic [NUM_CH-1:0]   edge_mode_o,
   output logic [NUM_CH-1:0]   pending_o,
   output logic                commit_o,
   output logic                cfg_error
);

   pwm_state_t        r_state;
   pwm_state_t        w_state_nxt;
   logic              r_cfg_error;
   logic              w_accept;
   logic              w_duty_ok;
   logic              w_legal;
   logic [NUM_CH-1:0] w_pend;
   logic [NUM_CH-1:0] w_pend_nxt;
   ch_cfg_t           w_wr_cfg;
   ch_cfg_t           w_active [NUM_CH];

   assign cfg_ready = reset_n && (r_state != ST_COMMIT);
   assign w_accept  = cfg_valid && cfg_ready;
   assign w_duty_ok = (cfg_duty <= 8'(DUTY_MAX));
   assign w_legal   = w_accept && w_duty_ok && (int'(cfg_channel) < NUM_CH);
   assign w_wr_cfg  = '{duty: cfg_duty, polarity: cfg_polarity, edge_mode: cfg_edge_mode};
   assign commit_o  = (r_state == ST_COMMIT);
   assign cfg_error = r_cfg_error;
   assign pending_o = w_pend;

   // A legal write in the period_end cycle lands in shadow on the same edge, so it joins this commit.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_PENDING: begin
            if (w_legal || (|w_pend)) w_state_nxt = period_end ? ST_COMMIT : ST_PENDING;
            else                      w_state_nxt = ST_IDLE;
         end
         ST_COMMIT: w_state_nxt = (|w_pend_nxt) ? ST_PENDING : ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_cfg_error <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cfg_error <= w_accept && !w_duty_ok;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pwm_cfg_shadow #(
         .RAMP_STEP (RAMP_STEP)
      ) u_shadow (
         .clk           (clk),
         .reset_n       (reset_n),
         .i_wr          (w_legal && (cfg_channel == 2'(g))),
         .i_wr_cfg      (w_wr_cfg),
         .i_commit      (commit_o),
         .o_active      (w_active[g]),
         .o_pending     (w_pend[g]),
         .o_pending_nxt (w_pend_nxt[g])
      );
      assign duty_o[8*g +: 8] = w_active[g].duty;
      assign polarity_o[g]    = w_active[g].polarity;
      assign edge_mode_o[g]   = w_active[g].edge_mode;
   end

endmodule

// File: tb/tb_pwm_cfg_controller.sv
// Bench for pwm_cfg_controller: directed scenarios plus random traffic against a behavioural model.
module tb_pwm_cfg_controller;

   localparam int NCH  = 4;
   localparam int DMAX = 100;
   localparam int STEP = 10;
`ifdef PWM_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [1:0]       cfg_channel = 2'd0;
   logic [7:0]       cfg_duty = 8'd0;
   logic             cfg_polarity = 1'b0;
   logic             cfg_edge_mode = 1'b0;
   logic             period_end = 1'b0;
   logic [8*NCH-1:0] duty_o;
   logic [NCH-1:0]   polarity_o;
   logic [NCH-1:0]   edge_mode_o;
   logic [NCH-1:0]   pending_o;
   logic             commit_o;
   logic             cfg_error;

   pwm_cfg_controller #(.NUM_CH(NCH), .DUTY_MAX(DMAX), .RAMP_STEP(STEP)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_channel   (cfg_channel),
      .cfg_duty      (cfg_duty),
      .cfg_polarity  (cfg_polarity),
      .cfg_edge_mode (cfg_edge_mode),
      .period_end    (period_end),
      .duty_o        (duty_o),
      .polarity_o    (polarity_o),
      .edge_mode_o   (edge_mode_o),
      .pending_o     (pending_o),
      .commit_o      (commit_o),
      .cfg_error     (cfg_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what each channel's shadow/active/pending must be, plus commit and error pulses.
   int m_sh_d [NCH];
   int m_act_d[NCH];
   bit m_sh_p [NCH];
   bit m_sh_e [NCH];
   bit m_act_p[NCH];
   bit m_act_e[NCH];
   bit m_pend [NCH];
   bit m_commit = 1'b0;
   bit m_err = 1'b0;

   function automatic int ramp_to(input int cur, input int tgt);
      if (!RAMP) return tgt;
      if (tgt > cur) return (tgt - cur > STEP) ? cur + STEP : tgt;
      return (cur - tgt > STEP) ? cur - STEP : tgt;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) begin
            m_sh_d[i] = 0; m_act_d[i] = 0; m_sh_p[i] = 0; m_sh_e[i] = 0;
            m_act_p[i] = 0; m_act_e[i] = 0; m_pend[i] = 0;
         end
         m_commit = 0;
         m_err = 0;
      end else if (m_commit) begin
         for (int i = 0; i < NCH; i++) begin
            if (m_pend[i]) begin
               m_act_p[i] = m_sh_p[i];
               m_act_e[i] = m_sh_e[i];
               m_act_d[i] = ramp_to(m_act_d[i], m_sh_d[i]);
               m_pend[i]  = (m_act_d[i] != m_sh_d[i]);
            end
         end
         m_commit = 0;
         m_err = 0;
      end else begin
         bit any;
         m_err = 0;
         if (cfg_valid) begin
            if (int'(cfg_duty) > DMAX) m_err = 1;
            else begin
               m_sh_d[cfg_channel] = int'(cfg_duty);
               m_sh_p[cfg_channel] = cfg_polarity;
               m_sh_e[cfg_channel] = cfg_edge_mode;
               m_pend[cfg_channel] = 1;
            end
         end
         any = 0;
         for (int i = 0; i < NCH; i++) any |= m_pend[i];
         if (period_end && any) m_commit = 1;
      end
   end

   always @(negedge clk) begin
      logic [8*NCH-1:0] ed;
      logic [NCH-1:0]   ep, ee, epd;
      for (int i = 0; i < NCH; i++) begin
         ed[8*i +: 8] = 8'(m_act_d[i]);
         ep[i] = m_act_p[i];
         ee[i] = m_act_e[i];
         epd[i] = m_pend[i];
      end
      check("m_cfg_ready", 64'(cfg_ready), 64'(reset_n && !m_commit));
      check("m_commit_o", 64'(commit_o), 64'(m_commit));
      check("m_cfg_error", 64'(cfg_error), 64'(m_err));
      check("m_pending_o", 64'(pending_o), 64'(epd));
      check("m_duty_o", 64'(duty_o), 64'(ed));
      check("m_polarity_o", 64'(polarity_o), 64'(ep));
      check("m_edge_mode_o", 64'(edge_mode_o), 64'(ee));
   end

   task automatic set_reset(input bit v);
      @(negedge clk);
      #1 reset_n = v;
   endtask

   task automatic do_write(input int ch, input int duty, input bit pol, input bit mode, input bit pe);
      bit done;
      done = 0;
      @(negedge clk);
      cfg_valid = 1; cfg_channel = 2'(ch); cfg_duty = 8'(duty);
      cfg_polarity = pol; cfg_edge_mode = mode; period_end = pe;
      for (int t = 0; t < 8 && !done; t++) begin
         done = cfg_ready;
         @(posedge clk);
         if (!done) begin
            @(negedge clk);
            period_end = 0;
         end
      end
      check("wr_accepted", 64'(done), 64'(1));
      @(negedge clk);
      cfg_valid = 0;
      period_end = 0;
   endtask

   task automatic pulse_pe();
      @(negedge clk);
      period_end = 1;
      @(negedge clk);
      period_end = 0;
   endtask

   int ramp_exp[4];

   initial begin
      if (RAMP) ramp_exp = '{10, 20, 30, 35};
      else      ramp_exp = '{35, 35, 35, 35};

      repeat (3) @(negedge clk);
      check("rst_duty", 64'(duty_o), 64'(0));
      check("rst_ready", 64'(cfg_ready), 64'(0));
      check("rst_commit", 64'(commit_o), 64'(0));
      set_reset(1);

      // ch1 40/1/1 committed two cycles after period_end
      do_write(1, 40, 1, 1, 0);
      pulse_pe();
      check("t1_commit_pulse", 64'(commit_o), 64'(1));
      check("t1_duty_before", 64'(duty_o[15:8]), 64'(0));
      @(negedge clk);
      check("t1_duty", 64'(duty_o), 64'h0000_2800);
      check("t1_pol", 64'(polarity_o), 64'(4'b0010));
      check("t1_mode", 64'(edge_mode_o), 64'(4'b0010));

      // illegal duty: error pulse, nothing pending, no commit
      do_write(2, 120, 0, 0, 0);
      check("t2_err_pulse", 64'(cfg_error), 64'(1));
      check("t2_pending", 64'(pending_o), 64'(0));
      @(negedge clk);
      check("t2_err_clear", 64'(cfg_error), 64'(0));
      pulse_pe();
      check("t2_no_commit", 64'(commit_o), 64'(0));
      do_write(2, 101, 0, 0, 0);
      check("t2_err_101", 64'(cfg_error), 64'(1));
      do_write(2, 100, 0, 0, 0);
      check("t2_ok_100", 64'(cfg_error), 64'(0));
      check("t2_pend_100", 64'(pending_o), 64'(4'b0100));

      // last write wins
      do_write(0, 30, 0, 1, 0);
      do_write(0, 70, 1, 0, 0);
      pulse_pe();
      @(negedge clk);
      check("t3_ch0_duty", 64'(duty_o[7:0]), RAMP ? 64'(10) : 64'(70));

      // write in the period_end cycle joins the commit
      do_write(3, 55, 1, 1, 1);
      check("t4_commit", 64'(commit_o), 64'(1));
      check("t4_ready_low", 64'(cfg_ready), 64'(0));
      @(negedge clk);
      check("t4_ready_high", 64'(cfg_ready), 64'(1));
      check("t4_ch3_duty", 64'(duty_o[31:24]), RAMP ? 64'(10) : 64'(55));
      check("t4_ch3_pol", 64'(polarity_o[3]), 64'(1));

      // ch0 0 -> 35
      set_reset(0);
      set_reset(1);
      do_write(0, 35, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         pulse_pe();
         @(negedge clk);
         check("t5_ramp_duty", 64'(duty_o[7:0]), 64'(ramp_exp[k]));
         check("t5_ramp_pend", 64'(pending_o[0]), 64'(RAMP && k < 3));
      end

      // reset while pending
      do_write(1, 60, 1, 0, 0);
      @(negedge clk);
      #1 reset_n = 0;
      #1;
      check("t6_pend_pending", 64'(pending_o), 64'(0));
      check("t6_pend_duty", 64'(duty_o), 64'(0));
      check("t6_pend_ready", 64'(cfg_ready), 64'(0));
      set_reset(1);

      // reset mid-COMMIT
      do_write(2, 50, 1, 1, 1);
      check("t7_in_commit", 64'(commit_o), 64'(1));
      #1 reset_n = 0;
      #1;
      check("t7_commit_o", 64'(commit_o), 64'(0));
      check("t7_ready", 64'(cfg_ready), 64'(0));
      check("t7_duty", 64'(duty_o), 64'(0));
      check("t7_pol", 64'(polarity_o), 64'(0));
      set_reset(1);
      @(negedge clk);
      check("t7_after_duty", 64'(duty_o), 64'(0));
      check("t7_after_pend", 64'(pending_o), 64'(0));
      pulse_pe();
      check("t7_idle_no_commit", 64'(commit_o), 64'(0));

      // random traffic against the model
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         cfg_valid     = ($urandom_range(0, 1) == 1);
         cfg_channel   = 2'($urandom_range(0, 3));
         cfg_duty      = 8'($urandom_range(0, 130));
         cfg_polarity  = 1'($urandom_range(0, 1));
         cfg_edge_mode = 1'($urandom_range(0, 1));
         period_end    = ($urandom_range(0, 6) == 0);
      end
      @(negedge clk);
      cfg_valid = 0;
      period_end = 0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
